// File: rtl/multi_channel_timer.sv
// NCH independent period timers: programmable terminal count, periodic or one-shot,
// pause/resume, wide completed-period count; a global sync clears and re-arms all channels.
module multi_channel_timer #(
  parameter int CW  = 17,
  parameter int PW  = 48,
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH-1:0]    oneshot,
  input  logic [NCH*CW-1:0] counter_max,
  input  logic              sync,
  output logic [NCH*CW-1:0] counter,
  output logic [NCH*PW-1:0] period,
  output logic [NCH-1:0]    period_done,
  output logic [NCH-1:0]    running
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] max_q;
    logic [PW-1:0] per_q;
    logic          done_q;
    logic          run_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        max_q   <= '0;
        per_q   <= '0;
        done_q  <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        max_q  <= counter_max[g*CW +: CW];
        done_q <= 1'b0;
        if (sync) begin
          // Sync wins over a coincident terminal: no pulse, no period increment.
          cnt_q <= '0;
          per_q <= '0;
          if (state_q == HALT) state_q <= IDLE;
        end else begin
          case (state_q)
            IDLE: begin
              if (enable[g]) begin
                state_q <= RUN;
                run_q   <= 1'b1;
              end
            end
            RUN: begin
              if (!enable[g]) begin
                state_q <= IDLE;
                run_q   <= 1'b0;
              end else if (cnt_q >= max_q) begin
                cnt_q  <= '0;
                done_q <= 1'b1;
                per_q  <= per_q + 1'b1;
                if (oneshot[g]) begin
                  state_q <= HALT;
                  run_q   <= 1'b0;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            HALT: begin
              if (!enable[g]) state_q <= IDLE;
            end
            default: begin
              state_q <= IDLE;
              run_q   <= 1'b0;
            end
          endcase
        end
      end
    end

    assign counter[g*CW +: CW] = cnt_q;
    assign period[g*PW +: PW]  = per_q;
    assign period_done[g]      = done_q;
    assign running[g]          = run_q;
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed and randomized checks of multi_channel_timer, plus a narrow-period wrap instance.
module tb_multi_channel_timer;
  localparam int CW  = 17;
  localparam int PW  = 48;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    enable, oneshot;
  logic [NCH*CW-1:0] counter_max;
  logic              sync;
  logic [NCH*CW-1:0] counter;
  logic [NCH*PW-1:0] period;
  logic [NCH-1:0]    period_done, running;

  logic       en8, os8, sync8;
  logic [3:0] max8, cnt8;
  logic [7:0] per8;
  logic       pd8, run8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_channel_timer #(.CW(CW), .PW(PW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .oneshot(oneshot),
    .counter_max(counter_max), .sync(sync), .counter(counter),
    .period(period), .period_done(period_done), .running(running)
  );

  multi_channel_timer #(.CW(4), .PW(8), .NCH(1)) dut8 (
    .clk(clk), .rst(rst), .enable(en8), .oneshot(os8),
    .counter_max(max8), .sync(sync8), .counter(cnt8),
    .period(per8), .period_done(pd8), .running(run8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return counter[ch*CW +: CW];
  endfunction

  function automatic logic [PW-1:0] per_of(input int ch);
    return period[ch*PW +: PW];
  endfunction

  task automatic set_max(input int ch, input int v);
    counter_max[ch*CW +: CW] = CW'(v);
  endtask

  typedef struct {
    logic en;
    int   cnt;
    logic run;
    logic pd;
  } vec_t;

  vec_t tbl[16];

  // Reference model state for the randomized phase
  bit          m_run [NCH];
  bit          m_halt[NCH];
  int          m_cnt [NCH];
  int          m_mx  [NCH];
  logic [PW-1:0] m_per[NCH];
  bit          m_pd  [NCH];

  initial begin
    int bad;

    tbl = '{
      '{1'b1, 0, 1'b1, 1'b0}, '{1'b1, 1, 1'b1, 1'b0}, '{1'b1, 2, 1'b1, 1'b0},
      '{1'b1, 3, 1'b1, 1'b0}, '{1'b1, 4, 1'b1, 1'b0}, '{1'b0, 4, 1'b0, 1'b0},
      '{1'b0, 4, 1'b0, 1'b0}, '{1'b0, 4, 1'b0, 1'b0}, '{1'b1, 4, 1'b1, 1'b0},
      '{1'b1, 5, 1'b1, 1'b0}, '{1'b1, 6, 1'b1, 1'b0}, '{1'b1, 7, 1'b1, 1'b0},
      '{1'b1, 8, 1'b1, 1'b0}, '{1'b1, 9, 1'b1, 1'b0}, '{1'b1, 0, 1'b1, 1'b1},
      '{1'b1, 1, 1'b1, 1'b0}
    };

    rst = 1'b1; enable = '0; oneshot = '0; counter_max = '0; sync = 1'b0;
    en8 = 1'b0; os8 = 1'b0; sync8 = 1'b0; max8 = '0;
    repeat (2) tick();
    chk("reset counter", 64'(counter), 0);
    chk("reset period", 64'(period[63:0]), 0);
    chk("reset period_done", 64'(period_done), 0);
    chk("reset running", 64'(running), 0);
    rst = 1'b0;

    // Periodic, max = {7,0,5,3}
    set_max(0, 3); set_max(1, 5); set_max(2, 0); set_max(3, 7);
    tick();
    enable = 4'hF;
    tick();
    chk("periodic entry running", 64'(running), 4'hF);
    chk("periodic entry ch0 counter", 64'(cnt_of(0)), 0);
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (cnt_of(0) != CW'(k % 4) || period_done[0] != (k % 4 == 0)) bad++;
      if (cnt_of(1) != CW'(k % 6) || cnt_of(3) != CW'(k % 8)) bad++;
      if (cnt_of(2) != 0 || period_done[2] != 1'b1) bad++;
    end
    chk("periodic sequence errors", 64'(bad), 0);
    chk("periodic ch0 period", 64'(per_of(0)), 10);
    chk("periodic ch1 period", 64'(per_of(1)), 6);
    chk("periodic ch2 period", 64'(per_of(2)), 40);
    chk("periodic ch3 period", 64'(per_of(3)), 5);

    // One-shot on ch1, max 5
    enable = '0; sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    oneshot = 4'b0010; enable = 4'b0010;
    tick();
    chk("oneshot entry running", 64'(running), 4'b0010);
    for (int k = 1; k <= 5; k++) tick();
    chk("oneshot pre-terminal counter", 64'(cnt_of(1)), 5);
    tick();
    chk("oneshot pulse", 64'(period_done), 4'b0010);
    chk("oneshot period 1", 64'(per_of(1)), 1);
    chk("oneshot halted running", 64'(running), 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (running[1] || cnt_of(1) != 0 || per_of(1) != 1 || period_done[1]) bad++;
    end
    chk("oneshot halt hold errors", 64'(bad), 0);
    enable = 4'b0000;
    tick();
    enable = 4'b0010;
    tick();
    chk("oneshot re-entry running", 64'(running), 4'b0010);
    repeat (5) tick();
    chk("oneshot no early pulse", 64'(period_done), 0);
    tick();
    chk("oneshot second pulse", 64'(period_done), 4'b0010);
    chk("oneshot period 2", 64'(per_of(1)), 2);

    // Pause/resume on ch0, max 9, table-driven
    enable = '0; oneshot = '0; set_max(0, 9); sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int i = 0; i < 16; i++) begin
      enable = {3'b000, tbl[i].en};
      tick();
      chk($sformatf("pause[%0d] counter", i), 64'(cnt_of(0)), 64'(tbl[i].cnt));
      chk($sformatf("pause[%0d] running", i), 64'(running[0]), 64'(tbl[i].run));
      chk($sformatf("pause[%0d] period_done", i), 64'(period_done[0]), 64'(tbl[i].pd));
    end

    // Lowering max below the current count on ch3
    enable = '0; sync = 1'b1;
    tick();
    sync = 1'b0; enable = 4'b1000;
    tick();
    repeat (6) tick();
    chk("maxchg counter at 6", 64'(cnt_of(3)), 6);
    set_max(3, 2);
    tick();
    chk("maxchg counter 7", 64'(cnt_of(3)), 7);
    chk("maxchg no pulse yet", 64'(period_done[3]), 0);
    tick();
    chk("maxchg wrap counter", 64'(cnt_of(3)), 0);
    chk("maxchg wrap pulse", 64'(period_done[3]), 1);
    tick(); tick();
    chk("maxchg new period count", 64'(cnt_of(3)), 2);
    tick();
    chk("maxchg 3-cycle period pulse", 64'(period_done[3]), 1);
    chk("maxchg period", 64'(per_of(3)), 2);

    // sync on ch0 terminal while ch1 is halted
    enable = '0; oneshot = '0; sync = 1'b1;
    tick();
    sync = 1'b0; set_max(0, 3); set_max(1, 0); oneshot = 4'b0010;
    tick();
    enable = 4'b0011;
    tick();
    tick(); tick(); tick();
    chk("sync setup ch0 counter", 64'(cnt_of(0)), 3);
    chk("sync setup ch1 halted", 64'(running), 4'b0001);
    sync = 1'b1;
    tick();
    chk("sync suppresses pulse", 64'(period_done), 0);
    chk("sync clears counters", 64'(counter), 0);
    chk("sync clears period ch0", 64'(per_of(0)), 0);
    chk("sync clears period ch1", 64'(per_of(1)), 0);
    chk("sync keeps RUN only", 64'(running), 4'b0001);
    sync = 1'b0;
    tick();
    chk("sync ch1 re-armed", 64'(running), 4'b0011);
    chk("sync ch0 restarts", 64'(cnt_of(0)), 1);

    // Randomized against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_run[ch] = 0; m_halt[ch] = 0; m_cnt[ch] = 0; m_mx[ch] = 0;
      m_per[ch] = '0; m_pd[ch] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      sync = ($urandom_range(0, 99) < 3);
      for (int ch = 0; ch < NCH; ch++) begin
        enable[ch]  = ($urandom_range(0, 9) < 8);
        oneshot[ch] = ($urandom_range(0, 9) < 2);
        if ($urandom_range(0, 9) == 0) set_max(ch, $urandom_range(0, 7));
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (sync) begin
          m_cnt[ch] = 0; m_per[ch] = '0; m_pd[ch] = 0; m_halt[ch] = 0;
        end else if (m_run[ch]) begin
          m_pd[ch] = 0;
          if (!enable[ch]) m_run[ch] = 0;
          else if (m_cnt[ch] >= m_mx[ch]) begin
            m_cnt[ch] = 0; m_pd[ch] = 1; m_per[ch] = m_per[ch] + 1;
            if (oneshot[ch]) begin m_run[ch] = 0; m_halt[ch] = 1; end
          end else m_cnt[ch] = m_cnt[ch] + 1;
        end else if (m_halt[ch]) begin
          m_pd[ch] = 0;
          if (!enable[ch]) m_halt[ch] = 0;
        end else begin
          m_pd[ch] = 0;
          if (enable[ch]) m_run[ch] = 1;
        end
        m_mx[ch] = int'(counter_max[ch*CW +: CW]);
      end
      tick();
      for (int ch = 0; ch < NCH; ch++) begin
        chk($sformatf("rand c%0d ch%0d counter", cyc, ch), 64'(cnt_of(ch)), 64'(m_cnt[ch]));
        chk($sformatf("rand c%0d ch%0d period", cyc, ch), 64'(per_of(ch)), 64'(m_per[ch]));
        chk($sformatf("rand c%0d ch%0d done", cyc, ch), 64'(period_done[ch]), 64'(m_pd[ch]));
        chk($sformatf("rand c%0d ch%0d running", cyc, ch), 64'(running[ch]), 64'(m_run[ch]));
      end
    end

    // Asynchronous reset between edges
    sync = 1'b0; oneshot = '0; enable = 4'hF;
    for (int ch = 0; ch < NCH; ch++) set_max(ch, 6);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("async rst counter", 64'(counter), 0);
    chk("async rst period low", 64'(period[63:0]), 0);
    chk("async rst period_done", 64'(period_done), 0);
    chk("async rst running", 64'(running), 0);
    tick();
    enable = '0;
    rst = 1'b0;
    tick();

    // 8-bit period wrap with max 0
    en8 = 1'b1;
    tick();
    chk("pw8 entry running", 64'(run8), 1);
    bad = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (pd8 !== 1'b1 || per8 !== 8'(k)) bad++;
      if (k == 255) chk("pw8 period 255", 64'(per8), 255);
      if (k == 256) chk("pw8 period wraps to 0", 64'(per8), 0);
    end
    chk("pw8 done/period errors", 64'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
